// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator operation sequencer.
package calc_pkg;

    typedef enum logic [2:0] {
        OpAdd     = 3'd0,
        OpSub     = 3'd1,
        OpMul     = 3'd2,
        OpDiv     = 3'd3,
        OpMplus   = 3'd4,
        OpMminus  = 3'd5,
        OpMrecall = 3'd6,
        OpMclear  = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        StIdle,
        StExec,
        StMulIt,
        StDivIt,
        StFin
    } state_e;

    localparam int unsigned IterCount  = 4;
    localparam logic [3:0]  NibbleZero = 4'h0;

    // Place a nibble in the low half of the 8-bit display result.
    function automatic logic [7:0] fmt_low(input logic [3:0] n);
        return {NibbleZero, n};
    endfunction

endpackage

// File: rtl/four_bit_adder_subtraction.sv
// Shared 4-bit adder/subtractor; on subtract, carry_out_o=1 means no borrow.
module four_bit_adder_subtraction (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       sub_i,
    input  logic       carry_in_i,
    output logic [3:0] result_o,
    output logic       carry_out_o
);

    logic [3:0] b_eff;

    assign b_eff = b_i ^ {4{sub_i}};
    assign {carry_out_o, result_o} = {1'b0, a_i} + {1'b0, b_eff} + {4'b0, carry_in_i ^ sub_i};

endmodule

// File: rtl/calc_op_sequencer.sv
// Control FSM that runs ADD/SUB/MUL/DIV and memory ops on one shared 4-bit adder.
module calc_op_sequencer
    import calc_pkg::*;
#(
    parameter logic [3:0] MEM_RESET_VALUE = 4'h0,
    parameter logic [3:0] DIV0_QUOTIENT   = 4'hF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] opcode,
    input  logic [3:0] operandA,
    input  logic [3:0] operandB,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       carryFlag,
    output logic       negFlag,
    output logic       errorFlag,
    output logic       memOverflow,
    output logic [3:0] memValue
);

    state_e     state_q, state_d;
    opcode_e    op_q, op_d;
    logic [3:0] a_q, a_d, b_q, b_d;
    logic [3:0] x_q, x_d, y_q, y_d;  // acc/mq for MUL, rem/q for DIV
    logic [1:0] cnt_q, cnt_d;
    logic [7:0] result_q, result_d;
    logic       carry_q, carry_d, neg_q, neg_d, err_q, err_d, movf_q, movf_d;
    logic [3:0] mem_q, mem_d, last_q, last_d;

    logic [3:0] add_a, add_b, add_sum;
    logic       add_sub, add_cout;
    logic [3:0] div_sh;
    logic [4:0] mul_sum;
    logic       div_take;

    assign div_sh = {x_q[2:0], y_q[3]};

    four_bit_adder_subtraction u_adder (
        .a_i         (add_a),
        .b_i         (add_b),
        .sub_i       (add_sub),
        .carry_in_i  (1'b0),
        .result_o    (add_sum),
        .carry_out_o (add_cout)
    );

    always_comb begin
        add_a   = a_q;
        add_b   = b_q;
        add_sub = 1'b0;
        case (state_q)
            StMulIt: begin
                add_a = x_q;
                add_b = a_q;
            end
            StDivIt: begin
                add_a   = div_sh;
                add_b   = b_q;
                add_sub = 1'b1;
            end
            StExec: begin
                case (op_q)
                    OpSub: add_sub = 1'b1;
                    OpMplus: begin
                        add_a = mem_q;
                        add_b = last_q;
                    end
                    OpMminus: begin
                        add_a   = mem_q;
                        add_b   = last_q;
                        add_sub = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign mul_sum  = y_q[0] ? {add_cout, add_sum} : {1'b0, x_q};
    assign div_take = x_q[3] | add_cout;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        x_d      = x_q;
        y_d      = y_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        neg_d    = neg_q;
        err_d    = err_q;
        movf_d   = movf_q;
        mem_d    = mem_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    op_d  = opcode_e'(opcode);
                    a_d   = operandA;
                    b_d   = operandB;
                    cnt_d = 2'd0;
                    x_d   = 4'h0;
                    y_d   = (opcode_e'(opcode) == OpDiv) ? operandA : operandB;
                    if (opcode_e'(opcode) == OpMul) begin
                        state_d = StMulIt;
                    end else if (opcode_e'(opcode) == OpDiv && operandB != 4'h0) begin
                        state_d = StDivIt;
                    end else begin
                        state_d = StExec;
                    end
                end
            end
            StMulIt: begin
                x_d   = mul_sum[4:1];
                y_d   = {mul_sum[0], y_q[3:1]};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(IterCount - 1)) state_d = StExec;
            end
            StDivIt: begin
                x_d   = div_take ? add_sum : div_sh;
                y_d   = {y_q[2:0], div_take};
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'(IterCount - 1)) state_d = StExec;
            end
            StExec: begin
                carry_d = 1'b0;
                neg_d   = 1'b0;
                err_d   = 1'b0;
                state_d = StFin;
                unique case (op_q)
                    OpAdd: begin
                        result_d = {3'b000, add_cout, add_sum};
                        carry_d  = add_cout;
                        last_d   = add_sum;
                    end
                    OpSub: begin
                        result_d = fmt_low(add_sum);
                        neg_d    = ~add_cout;
                        last_d   = add_sum;
                    end
                    OpMul, OpDiv: begin
                        if (op_q == OpDiv && b_q == 4'h0) begin
                            result_d = {a_q, DIV0_QUOTIENT};
                            err_d    = 1'b1;
                            last_d   = DIV0_QUOTIENT;
                        end else begin
                            result_d = {x_q, y_q};
                            last_d   = y_q;
                        end
                    end
                    OpMplus: begin
                        mem_d    = add_sum;
                        movf_d   = add_cout;
                        result_d = fmt_low(add_sum);
                    end
                    OpMminus: begin
                        mem_d    = add_sum;
                        movf_d   = ~add_cout;
                        neg_d    = ~add_cout;
                        result_d = fmt_low(add_sum);
                    end
                    OpMrecall: begin
                        movf_d   = 1'b0;
                        result_d = fmt_low(mem_q);
                    end
                    OpMclear: begin
                        movf_d   = 1'b0;
                        mem_d    = MEM_RESET_VALUE;
                        result_d = 8'h00;
                    end
                endcase
            end
            StFin: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= OpAdd;
            a_q      <= 4'h0;
            b_q      <= 4'h0;
            x_q      <= 4'h0;
            y_q      <= 4'h0;
            cnt_q    <= 2'd0;
            result_q <= 8'h00;
            carry_q  <= 1'b0;
            neg_q    <= 1'b0;
            err_q    <= 1'b0;
            movf_q   <= 1'b0;
            mem_q    <= MEM_RESET_VALUE;
            last_q   <= 4'h0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            x_q      <= x_d;
            y_q      <= y_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            neg_q    <= neg_d;
            err_q    <= err_d;
            movf_q   <= movf_d;
            mem_q    <= mem_d;
            last_q   <= last_d;
        end
    end

    assign busy        = (state_q == StExec) || (state_q == StMulIt) || (state_q == StDivIt);
    assign done        = (state_q == StFin);
    assign result      = result_q;
    assign carryFlag   = carry_q;
    assign negFlag     = neg_q;
    assign errorFlag   = err_q;
    assign memOverflow = movf_q;
    assign memValue    = mem_q;

endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer with hand-computed expectations.
module tb_calc_op_sequencer;

    logic       clk, rst_n, start;
    logic [2:0] opcode;
    logic [3:0] operandA, operandB;
    logic       busy, done, carryFlag, negFlag, errorFlag, memOverflow;
    logic [7:0] result;
    logic [3:0] memValue;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, MUL = 3'd2, DIV = 3'd3;
    localparam logic [2:0] MPL = 3'd4, MMI = 3'd5, MRC = 3'd6, MCL = 3'd7;

    calc_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .opcode      (opcode),
        .operandA    (operandA),
        .operandB    (operandB),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .carryFlag   (carryFlag),
        .negFlag     (negFlag),
        .errorFlag   (errorFlag),
        .memOverflow (memOverflow),
        .memValue    (memValue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Starts in the cycle after the caller's current one; returns in the done cycle.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input int lat);
        int cyc;
        @(negedge clk);
        opcode = op; operandA = a; operandB = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 20) begin
            check({tag, "_busy"}, 8'(busy), 8'd1);
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, 8'(cyc), 8'(lat));
        check({tag, "_busy_at_done"}, 8'(busy), 8'd0);
    endtask

    initial begin
        int ndone;
        int first;
        rst_n = 1'b0; start = 1'b0; opcode = 3'd0; operandA = 4'h0; operandB = 4'h0;
        #12;
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_result", result, 8'h00);
        check("rst_flags", {4'h0, carryFlag, negFlag, errorFlag, memOverflow}, 8'h00);
        check("rst_mem", 8'(memValue), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add_9_8", ADD, 4'd9, 4'd8, 2);
        check("add_9_8_res", result, 8'h11);
        check("add_9_8_carry", 8'(carryFlag), 8'd1);
        check("add_9_8_neg", 8'(negFlag), 8'd0);

        run_op("sub_3_5", SUB, 4'd3, 4'd5, 2);
        check("sub_3_5_res", result, 8'h0E);
        check("sub_3_5_neg", 8'(negFlag), 8'd1);
        check("sub_3_5_carry", 8'(carryFlag), 8'd0);
        run_op("sub_5_3", SUB, 4'd5, 4'd3, 2);
        check("sub_5_3_res", result, 8'h02);
        check("sub_5_3_neg", 8'(negFlag), 8'd0);

        run_op("mul_15_15", MUL, 4'd15, 4'd15, 6);
        check("mul_15_15_res", result, 8'hE1);
        check("mul_15_15_flags", {5'h0, carryFlag, negFlag, errorFlag}, 8'h00);
        run_op("mul_0_7", MUL, 4'd0, 4'd7, 6);
        check("mul_0_7_res", result, 8'h00);

        run_op("div_13_4", DIV, 4'd13, 4'd4, 6);
        check("div_13_4_res", result, 8'h13);
        check("div_13_4_err", 8'(errorFlag), 8'd0);
        run_op("div_7_0", DIV, 4'd7, 4'd0, 2);
        check("div_7_0_res", result, 8'h7F);
        check("div_7_0_err", 8'(errorFlag), 8'd1);
        run_op("div_15_1", DIV, 4'd15, 4'd1, 6);
        check("div_15_1_res", result, 8'h0F);
        check("div_15_1_err", 8'(errorFlag), 8'd0);

        run_op("mclear", MCL, 4'd0, 4'd0, 2);
        check("mclear_res", result, 8'h00);
        check("mclear_mem", 8'(memValue), 8'h00);
        run_op("add_6_7", ADD, 4'd6, 4'd7, 2);
        check("add_6_7_res", result, 8'h0D);
        check("add_6_7_carry", 8'(carryFlag), 8'd0);
        run_op("mplus1", MPL, 4'd0, 4'd0, 2);
        check("mplus1_mem", 8'(memValue), 8'h0D);
        check("mplus1_ovf", 8'(memOverflow), 8'd0);
        check("mplus1_res", result, 8'h0D);
        run_op("mplus2", MPL, 4'd0, 4'd0, 2);
        check("mplus2_mem", 8'(memValue), 8'h0A);
        check("mplus2_ovf", 8'(memOverflow), 8'd1);
        run_op("mrecall", MRC, 4'd0, 4'd0, 2);
        check("mrecall_res", result, 8'h0A);
        check("mrecall_ovf", 8'(memOverflow), 8'd0);
        run_op("mminus", MMI, 4'd0, 4'd0, 2);
        check("mminus_mem", 8'(memValue), 8'h0D);
        check("mminus_neg", 8'(negFlag), 8'd1);
        check("mminus_ovf", 8'(memOverflow), 8'd1);
        check("mminus_res", result, 8'h0D);

        // MUL 3*5 with a second start in cycle 2 that must be dropped.
        @(negedge clk);
        opcode = MUL; operandA = 4'd3; operandB = 4'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        opcode = ADD; operandA = 4'd1; operandB = 4'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        first = 0;
        for (int k = 3; k <= 12; k++) begin
            if (done) begin
                ndone++;
                if (first == 0) first = k;
            end
            @(negedge clk);
        end
        check("ignored_start_ndone", 8'(ndone), 8'd1);
        check("ignored_start_lat", 8'(first), 8'd6);
        check("ignored_start_res", result, 8'h0F);

        // Reset in cycle 3 of a MUL aborts it with no done afterwards.
        opcode = MUL; operandA = 4'd15; operandB = 4'd15; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", 8'(busy), 8'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", 8'(busy), 8'd0);
        check("midrst_result", result, 8'h00);
        check("midrst_mem", 8'(memValue), 8'h00);
        check("midrst_flags", {4'h0, carryFlag, negFlag, errorFlag, memOverflow}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("post_rst_no_done", 8'(ndone), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
